// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the combinational instruction memory and
// feeds the IF/ID register toward decode. Define FETCH_PERF_EN to add fetch/stall counters.
module fetch_unit #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               id_ready,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc,
    output logic [ADDR_W-1:0]  id_pc_next
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        perf_fetched,
    output logic [15:0]        perf_stall
`endif
);

    typedef enum logic [1:0] {
        ACT_RESET,
        ACT_REDIRECT,
        ACT_HOLD,
        ACT_ADVANCE
    } action_e;

    logic [ADDR_W-1:0]  r_pc;
    logic               r_id_valid;
    logic [INSTR_W-1:0] r_id_instr;
    logic [ADDR_W-1:0]  r_id_pc;
    logic [ADDR_W-1:0]  r_id_pc_next;

    action_e            w_action;
    logic [ADDR_W-1:0]  w_pc_inc;
    logic               w_transfer;

    // Unsigned increment truncates to ADDR_W bits, so the last word wraps to 0.
    assign w_pc_inc   = r_pc + ADDR_W'(1);
    assign w_transfer = r_id_valid && id_ready;

    // NOTE: always_comb assigns a default before any branch so no latch can be inferred.
    always_comb begin
        w_action = ACT_ADVANCE;
        if (reset) begin
            w_action = ACT_RESET;
        end else if (redirect_valid) begin
            w_action = ACT_REDIRECT;
        end else if (r_id_valid && !id_ready) begin
            w_action = ACT_HOLD;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        unique case (w_action)
            ACT_RESET: begin
                r_pc         <= RESET_PC;
                r_id_valid   <= 1'b0;
                r_id_instr   <= '0;
                r_id_pc      <= '0;
                r_id_pc_next <= '0;
            end
            ACT_REDIRECT: begin
                r_pc       <= redirect_pc;
                r_id_valid <= 1'b0;
            end
            ACT_HOLD: begin
                r_pc <= r_pc;
            end
            default: begin
                r_pc         <= w_pc_inc;
                r_id_valid   <= 1'b1;
                r_id_instr   <= imem_instr;
                r_id_pc      <= r_pc;
                r_id_pc_next <= w_pc_inc;
            end
        endcase
    end

    assign imem_addr  = r_pc;
    assign id_valid   = r_id_valid;
    assign id_instr   = r_id_instr;
    assign id_pc      = r_id_pc;
    assign id_pc_next = r_id_pc_next;

`ifdef FETCH_PERF_EN
    logic [15:0] r_perf_fetched;
    logic [15:0] r_perf_stall;

    // Counters saturate and ignore redirects; a transfer coinciding with a redirect still counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_transfer && (r_perf_fetched != 16'hFFFF)) begin
                r_perf_fetched <= r_perf_fetched + 16'd1;
            end
            if ((w_action == ACT_HOLD) && (r_perf_stall != 16'hFFFF)) begin
                r_perf_stall <= r_perf_stall + 16'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`else
    logic w_unused;
    assign w_unused = w_transfer;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the decoder and the addressing master of instruction_memory. Holds the program counter (PC) and drives the word address into the combinational instruction memory. Registers the returned 16-bit instruction into an IF/ID pipeline register with a valid/ready handshake toward decode. Accepts PC redirects from the branch-resolution logic, for example a taken BEQ.

Parameters:
ADDR_W, 10, PC / instruction-memory word-address width (1024 words)
INSTR_W, 16, instruction width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  single system clock, rising edge
reset  input  1  synchronous, active-high reset
imem_addr  output  ADDR_W  word address to instruction memory; always equals the current PC
imem_instr  input  INSTR_W  instruction memory read data; combinational from imem_addr, same cycle
redirect_valid  input  1  branch/jump taken this cycle; load redirect_pc
redirect_pc  input  ADDR_W  redirect target word address
id_ready  input  1  decoder can accept the IF/ID contents this cycle
id_valid  output  1  IF/ID register holds a valid instruction
id_instr  output  INSTR_W  fetched instruction
id_pc  output  ADDR_W  address the instruction in id_instr was fetched from
id_pc_next  output  ADDR_W  id_pc + 1, modulo 2^ADDR_W (branch base for decode)

Behaviour:
- All state updates occur on the rising edge of clk. Priority per cycle: reset > redirect > hold > advance.
- Reset (reset=1): pc<=RESET_PC; id_valid<=0; id_instr<=0; id_pc<=0; id_pc_next<=0.
- Redirect (redirect_valid=1): pc<=redirect_pc; id_valid<=0 (flush the wrong-path instruction); id_instr and id_pc are don't-care and must not be relied on. Redirect wins over backpressure.
- Hold (id_valid=1 and id_ready=0): pc, id_valid, id_instr, id_pc and id_pc_next are all unchanged. imem_addr stays stable.
- Advance (all other cases, including id_valid=0):
  - id_instr<=imem_instr; id_pc<=pc; id_pc_next<=pc+1; id_valid<=1; pc<=pc+1.
- Handshake: a transfer occurs on a cycle with id_valid=1 and id_ready=1. id_valid never deasserts without a transfer unless a redirect or reset occurs.
- Latency: the instruction at address A appears on id_instr exactly 1 cycle after pc==A, provided no hold or redirect occurs. Steady-state throughput is 1 instruction/cycle.
- After reset deasserts: first cycle id_valid=0 and imem_addr=RESET_PC. The next cycle presents id_instr=mem[RESET_PC] with id_valid=1.
- After a redirect: one bubble cycle (id_valid=0), then mem[redirect_pc] is valid.
- Wrap-around: the PC increment is modulo 2^ADDR_W, so 1023+1=0 with no error flag. id_pc_next wraps identically.
- Redirect while holding: the flush occurs and the held instruction is discarded.
- Reset mid-stall or mid-redirect: reset values apply; no residual state.
- Arithmetic: unsigned ADDR_W-bit add; no sign handling (branch offsets are resolved downstream into redirect_pc).

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds outputs perf_fetched (16 bit) and perf_stall (16 bit).
  - perf_fetched increments on each handshake transfer.
  - perf_stall increments on each hold cycle.
  - Both saturate at 16'hFFFF, clear on reset, and are not affected by redirect.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Preload mem[0..2] = 16'h2C06, 16'h2406, 16'h0083; hold id_ready=1; release reset -> cycle0 id_valid=0, imem_addr=0; cycle1 id_instr=16'h2C06, id_pc=0, id_pc_next=1; cycle2 16'h2406, id_pc=1; cycle3 16'h0083, id_pc=2.
- Drive id_ready=0 for 3 cycles while id_pc=2 -> id_instr, id_pc=2 and imem_addr=3 held all 3 cycles; id_ready=1 -> next cycle id_pc=3.
- Pulse redirect_valid=1 with redirect_pc=1 while pc=4 -> next cycle id_valid=0 and imem_addr=1; following cycle id_pc=1, id_instr=mem[1].
- Drive redirect_valid=1 (redirect_pc=5) on the same cycle as id_valid=1 and id_ready=0 -> flush wins: next cycle id_valid=0, imem_addr=5.
- Redirect to 1023 -> id_pc=1023 with id_pc_next=0, then id_pc=0 on the next cycle.
- Assert reset during a hold -> next cycle id_valid=0, imem_addr=RESET_PC, id_instr=0. With FETCH_PERF_EN defined, a run of 4 transfers and 3 stalls gives perf_fetched=4 and perf_stall=3.
